// File: rtl/garage_input_conditioner.sv
// Input conditioning for the garage door controller: per-input 2-flop sync and debounce,
// plus a press-to-pulse FSM with limit-fault gating and post-release lockout.
module garage_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 5,
    parameter int unsigned LOCKOUT_CYCLES  = 64,
    parameter int unsigned LOCK_W          = 7
) (
    input  logic CLK,
    input  logic RST,
    input  logic Btn_Raw,
    input  logic Up_Raw,
    input  logic Dn_Raw,
    output logic Activate,
    output logic Up_Max,
    output logic Dn_Max,
    output logic Lim_Fault
);

    typedef enum logic [1:0] {
        WAIT_PRESS = 2'b00,
        PRESSED    = 2'b01,
        LOCKOUT    = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0]  DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_END = LOCK_W'(LOCKOUT_CYCLES - 1);

    // Channel order in the vectors below: bit 0 button, bit 1 upper limit, bit 2 lower limit.
    logic [2:0]       raw;
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       stable;
    logic [CNT_W-1:0] db_cnt [3];

    logic              btn_db;
    state_t            state;
    state_t            state_next;
    logic [LOCK_W-1:0] lock_cnt;
    logic [LOCK_W-1:0] lock_next;
    logic              act_next;

    assign raw = {Dn_Raw, Up_Raw, Btn_Raw};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // A mismatch must persist DEBOUNCE_CYCLES consecutive samples; any agreement restarts it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stable <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign btn_db = stable[0];
    assign Up_Max = stable[1];
    assign Dn_Max = stable[2];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Lim_Fault <= 1'b0;
        end else begin
            Lim_Fault <= stable[1] & stable[2];
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= WAIT_PRESS;
            lock_cnt <= '0;
            Activate <= 1'b0;
        end else begin
            state    <= state_next;
            lock_cnt <= lock_next;
            Activate <= act_next;
        end
    end

    // Pulse gating uses the registered fault seen before this edge.
    always_comb begin
        state_next = state;
        lock_next  = lock_cnt;
        act_next   = 1'b0;
        case (state)
            WAIT_PRESS: begin
                if (btn_db) begin
                    state_next = PRESSED;
                    act_next   = ~Lim_Fault;
                end
            end
            PRESSED: begin
                if (!btn_db) begin
                    state_next = LOCKOUT;
                    lock_next  = '0;
                end
            end
            LOCKOUT: begin
                lock_next = lock_cnt + LOCK_W'(1);
                if (lock_next >= LOCK_END) begin
                    state_next = WAIT_PRESS;
                end
            end
            default: begin
                state_next = WAIT_PRESS;
                lock_next  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_garage_input_conditioner.sv
// Directed table-driven bench for garage_input_conditioner (DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8).
module tb_garage_input_conditioner;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_raw = 1'b0;
    logic up_raw = 1'b0;
    logic dn_raw = 1'b0;
    logic activate;
    logic up_max;
    logic dn_max;
    logic lim_fault;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic btn;
        logic up;
        logic dn;
        logic act;
        logic upm;
        logic dnm;
        logic flt;
    } vec_t;

    vec_t vecs[$];

    garage_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(5),
        .LOCKOUT_CYCLES(8),
        .LOCK_W(7)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .Btn_Raw(btn_raw),
        .Up_Raw(up_raw),
        .Dn_Raw(dn_raw),
        .Activate(activate),
        .Up_Max(up_max),
        .Dn_Max(dn_max),
        .Lim_Fault(lim_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at step %0d: got %b, expected %b", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int idx,
                           input logic a, input logic u, input logic d, input logic f);
        chk({tag, ".Activate"}, idx, activate, a);
        chk({tag, ".Up_Max"}, idx, up_max, u);
        chk({tag, ".Dn_Max"}, idx, dn_max, d);
        chk({tag, ".Lim_Fault"}, idx, lim_fault, f);
    endtask

    task automatic add(input int n, input logic b, input logic u, input logic d,
                       input logic a, input logic um, input logic dm, input logic f);
        vec_t v;
        v.btn = b; v.up = u; v.dn = d;
        v.act = a; v.upm = um; v.dnm = dm; v.flt = f;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Upper limit rises: visible after the 6th edge (index 5).
        add(5, 0, 1, 0,  0, 0, 0, 0);
        add(3, 0, 1, 0,  0, 1, 0, 0);
        // Single-cycle dropouts on the upper limit never debounce.
        for (int i = 0; i < 10; i++) begin
            add(1, 0, 0, 0,  0, 1, 0, 0);
            add(1, 0, 1, 0,  0, 1, 0, 0);
        end
        // Press 10 cycles, brief release, re-press lands 3 cycles into lockout.
        add(6,  1, 1, 0,  0, 1, 0, 0);
        add(1,  1, 1, 0,  1, 1, 0, 0);
        add(3,  1, 1, 0,  0, 1, 0, 0);
        add(4,  0, 1, 0,  0, 1, 0, 0);
        add(10, 1, 1, 0,  0, 1, 0, 0);
        add(1,  1, 1, 0,  1, 1, 0, 0);
        add(5,  1, 1, 0,  0, 1, 0, 0);
        add(16, 0, 1, 0,  0, 1, 0, 0);
        // Both limits closed: fault, press consumed; fault clears, next press pulses.
        add(5,  0, 1, 1,  0, 1, 0, 0);
        add(1,  0, 1, 1,  0, 1, 1, 0);
        add(1,  0, 1, 1,  0, 1, 1, 1);
        add(10, 1, 1, 1,  0, 1, 1, 1);
        add(5,  0, 1, 0,  0, 1, 1, 1);
        add(1,  0, 1, 0,  0, 1, 0, 1);
        add(10, 0, 1, 0,  0, 1, 0, 0);
        add(6,  1, 1, 0,  0, 1, 0, 0);
        add(1,  1, 1, 0,  1, 1, 0, 0);
        add(3,  1, 1, 0,  0, 1, 0, 0);

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            btn_raw = vecs[i].btn;
            up_raw  = vecs[i].up;
            dn_raw  = vecs[i].dn;
            @(posedge clk);
            #1;
            chk_all("table", i, vecs[i].act, vecs[i].upm, vecs[i].dnm, vecs[i].flt);
        end

        // Asynchronous reset while PRESSED with Up_Max high, button still held.
        #3;
        rst = 1'b0;
        #1;
        chk_all("async_rst", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_all("rst_hold", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            chk_all("post_rst", k, (k == 6), (k >= 5), 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
